fir3_tap_sequencer: RTL

FIR3_TAP_SEQUENCER -- requirements
Module: fir3_tap_sequencer

---
 rtl/fir3_tap_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/fir3_tap_sequencer.sv
// Sequencer for a 3-tap FIR datapath: arbitrates sample and coefficient traffic
// and drives the shift enable, tap-select codes and output qualification.
module fir3_tap_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       coef_req,
    input  logic [1:0] coef_idx,
    input  logic [7:0] coef_data,
    output logic       coef_ack,
    output logic [7:0] x,
    output logic [7:0] c_bus,
    output logic       ca0,
    output logic       ca1,
    output logic       cen,
    output logic       y_valid,
    output logic       filling,
    input  logic       y_ready
);

    typedef enum logic [1:0] {IDLE, COEF, SHIFT} state_t;

    localparam logic [1:0] CA_HOLD = 2'b11;

    state_t     state_reg, state_next;
    logic [7:0] x_reg, x_next;
    logic [7:0] c_bus_reg, c_bus_next;
    logic [1:0] ca_reg, ca_next;
    logic [1:0] fc_reg, fc_next;
    logic       y_valid_reg, y_valid_next;
    logic       coef_prio_reg, coef_prio_next;

    logic sample_ok;
    logic grant_coef;
    logic grant_sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            x_reg         <= 8'h00;
            c_bus_reg     <= 8'h00;
            ca_reg        <= CA_HOLD;
            fc_reg        <= 2'd0;
            y_valid_reg   <= 1'b0;
            coef_prio_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            c_bus_reg     <= c_bus_next;
            ca_reg        <= ca_next;
            fc_reg        <= fc_next;
            y_valid_reg   <= y_valid_next;
            coef_prio_reg <= coef_prio_next;
        end
    end

    always_comb begin
        // An unconsumed output blocks new samples so y is never overwritten.
        sample_ok    = s_valid && !(y_valid_reg && !y_ready);
        grant_coef   = (state_reg == IDLE) && coef_req && (!sample_ok || coef_prio_reg);
        grant_sample = (state_reg == IDLE) && sample_ok && !grant_coef;

        state_next     = IDLE;
        x_next         = x_reg;
        c_bus_next     = c_bus_reg;
        ca_next        = CA_HOLD;
        fc_next        = fc_reg;
        y_valid_next   = y_valid_reg;
        coef_prio_next = coef_prio_reg;

        case (state_reg)
            IDLE: begin
                if (grant_coef) begin
                    state_next     = COEF;
                    ca_next        = coef_idx;
                    coef_prio_next = 1'b0;
                    if (coef_idx != CA_HOLD) begin
                        c_bus_next = coef_data;
                    end
                end else if (grant_sample) begin
                    state_next     = SHIFT;
                    x_next         = s_data;
                    coef_prio_next = 1'b1;
                end
            end
            COEF: begin
                if (ca_reg != CA_HOLD) begin
                    fc_next = 2'd0;
                end
            end
            SHIFT: begin
                if (fc_reg != 2'd3) begin
                    fc_next = fc_reg + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A fresh qualification takes precedence over consumption in the same cycle.
        if (state_reg == SHIFT && fc_reg == 2'd3) begin
            y_valid_next = 1'b1;
        end else if (y_valid_reg && y_ready) begin
            y_valid_next = 1'b0;
        end
    end

    assign s_ready  = grant_sample;
    assign coef_ack = grant_coef;
    assign x        = x_reg;
    assign c_bus    = c_bus_reg;
    assign ca0      = ca_reg[0];
    assign ca1      = ca_reg[1];
    assign cen      = (state_reg == SHIFT);
    assign y_valid  = y_valid_reg;
    assign filling  = (fc_reg != 2'd3);

endmodule
